sm_regdump: RTL and testbench

- Register-file reader for the core's debug read port. It drives the debug register address (regAddr) and samples the returned debug data (regData).
- It sequences through registers and streams each captured value out over a valid/ready interface, for the UART/LED debug path or a testbench scoreboard.
- It runs alongside the datapath and never stalls the core; each value is a snapshot taken at its capture cycle.

---
 rtl/sm_regdump_pkg.sv | 15 +
 rtl/sm_regdump_if.sv | 27 ++
 rtl/flopr.sv | 14 +
 rtl/sm_regdump.sv | 106 ++++++++++
 tb/tb_sm_regdump.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the debug register-dump sequencer.
package sm_regdump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

    // Index whose debug read returns the core's PC+8 instead of a GPR.
    localparam logic [3:0] REG_PC = 4'd15;

    localparam int DEFAULT_SETTLE = 1;

endpackage

// File: rtl/sm_regdump_if.sv
// Valid/ready stream carrying captured register words out of the dump sequencer.
interface sm_regdump_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/flopr.sv
// Resettable D flip-flop bank, shared register primitive of the codebase.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

// File: rtl/sm_regdump.sv
// Debug register-file reader: walks the core's debug read port and streams
// each snapshot over a valid/ready interface without stalling the core.
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int SETTLE   = DEFAULT_SETTLE
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    sm_regdump_if.master      out_if,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0]        ST_IDLE  = IDLE;
    localparam logic [1:0]        ST_WAIT  = WAIT;
    localparam logic [1:0]        ST_SEND  = SEND;
    localparam logic [3:0]        CNT_INIT = 4'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic              single_q;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic              hs;

    assign hs = out_if.out_valid && out_if.out_ready;

    // addr only moves on a new request or after a non-final handshake, so
    // regAddr stays frozen while a word is being offered.
    always_comb begin
        addr_nxt = addr;
        if (state == ST_IDLE && start)
            addr_nxt = single ? start_addr : '0;
        else if (state == ST_SEND && hs && !out_if.out_last)
            addr_nxt = addr + 1'b1;
    end

    flopr #(.WIDTH(ADDR_W)) u_addr (
        .clk   (clk),
        .reset (rst_p),
        .d     (addr_nxt),
        .q     (addr)
    );

    assign regAddr = addr;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state            <= ST_IDLE;
            single_q         <= 1'b0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_index <= '0;
            out_if.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        single_q <= single;
                        cnt      <= CNT_INIT;
                        busy     <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        out_if.out_data  <= regData;
                        out_if.out_index <= addr;
                        out_if.out_last  <= single_q || (addr == LAST_IDX);
                        out_if.out_valid <= 1'b1;
                        state            <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        if (out_if.out_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= ST_WAIT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: expected words are queued per request from a register
// model and compared at every handshake on the output stream.
module tb_sm_regdump;
    import sm_regdump_pkg::*;

    logic        clk = 1'b0;
    logic        rst_p, start, start3, single;
    logic [3:0]  start_addr;
    logic [3:0]  reg_addr, reg_addr3;
    logic [3:0]  prev3 = 4'd0;
    logic [31:0] reg_data, reg_data3, pc;
    logic [31:0] rf [16];
    logic        busy, done, busy3, done3;
    int          age3 = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] q_data [$];
    logic [3:0]  q_idx [$];
    logic        q_last [$];

    sm_regdump_if #(.ADDR_W(4), .DATA_W(32)) sif ();
    sm_regdump_if #(.ADDR_W(4), .DATA_W(32)) sif3 ();

    sm_regdump #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32), .SETTLE(1)) u_dut (
        .clk(clk), .rst_p(rst_p), .start(start), .single(single), .start_addr(start_addr),
        .regAddr(reg_addr), .regData(reg_data), .out_if(sif), .busy(busy), .done(done)
    );

    sm_regdump #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_p(rst_p), .start(start3), .single(single), .start_addr(start_addr),
        .regAddr(reg_addr3), .regData(reg_data3), .out_if(sif3), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    // Register file model; index 15 reads PC+8.
    always_comb reg_data = (reg_addr == REG_PC) ? pc + 32'd8 : rf[reg_addr];

    // Slow register model: the new value appears 2 cycles after the address changes.
    always @(posedge clk) begin
        prev3 <= reg_addr3;
        if (reg_addr3 != prev3) age3 <= 1;
        else if (age3 < 7)      age3 <= age3 + 1;
    end
    always_comb reg_data3 = (age3 >= 2) ? (rf[reg_addr3] ^ 32'hFFFF_0000) : 32'h0BAD_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] idx, input logic last, input logic slow);
        logic [31:0] d;
        if (slow) d = rf[idx] ^ 32'hFFFF_0000;
        else      d = (idx == REG_PC) ? pc + 32'd8 : rf[idx];
        q_data.push_back(d);
        q_idx.push_back(idx);
        q_last.push_back(last);
    endtask

    task automatic push_full(input logic slow);
        for (int i = 0; i < 16; i++) push_word(4'(i), (i == 15), slow);
    endtask

    task automatic kick(input logic sgl, input logic [3:0] a, input logic on3);
        single     = sgl;
        start_addr = a;
        if (on3) start3 = 1'b1;
        else     start  = 1'b1;
        tick();
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic test_reset();
        rst_p = 1'b1;
        tick();
        tick();
        checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || reg_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b busy=%b done=%b addr=%0d required 0 0 0 0",
                     sif.out_valid, busy, done, reg_addr);
        end
        checks++;
        if (sif.out_data !== 32'd0 || sif.out_index !== 4'd0 || sif.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got data=%h idx=%0d last=%b required 0 0 0",
                     sif.out_data, sif.out_index, sif.out_last);
        end
        checks++;
        if (sif3.out_valid !== 1'b0 || busy3 !== 1'b0 || reg_addr3 !== 4'd0) begin
            errors++;
            $display("FAIL reset_dut3 got valid=%b busy=%b addr=%0d required 0 0 0",
                     sif3.out_valid, busy3, reg_addr3);
        end
        rst_p = 1'b0;
        tick();
    endtask

    task automatic test_full_dump();
        int words = 0, dones = 0, done_cyc = -1;
        logic [31:0] ed;
        logic [3:0]  ei;
        logic        el;
        push_full(1'b0);
        kick(1'b0, 4'd9, 1'b0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (sif.out_valid && sif.out_ready) begin
                words++;
                checks++;
                if (q_data.size() == 0) begin
                    errors++;
                    $display("FAIL full_word got extra idx=%0d required none", sif.out_index);
                end else begin
                    ed = q_data.pop_front(); ei = q_idx.pop_front(); el = q_last.pop_front();
                    if (sif.out_data !== ed || sif.out_index !== ei || sif.out_last !== el) begin
                        errors++;
                        $display("FAIL full_word got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                 sif.out_index, sif.out_data, sif.out_last, ei, ed, el);
                    end
                end
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            tick();
        end
        checks++;
        if (done_cyc != 33 || dones != 1) begin
            errors++;
            $display("FAIL full_done got cycle=%0d pulses=%0d required 33 1", done_cyc, dones);
        end
        checks++;
        if (words != 16 || q_data.size() != 0) begin
            errors++;
            $display("FAIL full_count got words=%0d left=%0d required 16 0", words, q_data.size());
        end
        checks++;
        if (busy !== 1'b0 || reg_addr !== 4'd15) begin
            errors++;
            $display("FAIL full_idle got busy=%b addr=%0d required 0 15", busy, reg_addr);
        end
    endtask

    task automatic test_single();
        logic [3:0]  a;
        logic [31:0] ed;
        logic [3:0]  ei;
        logic        el;
        rf[7] = 32'hDEAD_BEEF;
        for (int n = 0; n < 2; n++) begin
            int words = 0, first_v = -1, hs_cyc = -1, done_cyc = -1;
            a = (n == 0) ? 4'd7 : 4'd15;
            push_word(a, 1'b1, 1'b0);
            kick(1'b1, a, 1'b0);
            for (int cyc = 1; cyc <= 10; cyc++) begin
                @(negedge clk);
                if (sif.out_valid && first_v < 0) first_v = cyc;
                if (sif.out_valid && sif.out_ready) begin
                    words++;
                    hs_cyc = cyc;
                    checks++;
                    if (q_data.size() == 0) begin
                        errors++;
                        $display("FAIL single_word got extra idx=%0d required none", sif.out_index);
                    end else begin
                        ed = q_data.pop_front(); ei = q_idx.pop_front(); el = q_last.pop_front();
                        if (sif.out_data !== ed || sif.out_index !== ei || sif.out_last !== el) begin
                            errors++;
                            $display("FAIL single_word got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                     sif.out_index, sif.out_data, sif.out_last, ei, ed, el);
                        end
                    end
                end
                if (done && done_cyc < 0) done_cyc = cyc;
                tick();
            end
            checks++;
            if (words != 1 || first_v != 2) begin
                errors++;
                $display("FAIL single_timing addr=%0d got words=%0d valid_cycle=%0d required 1 2",
                         a, words, first_v);
            end
            checks++;
            if (done_cyc != hs_cyc + 1) begin
                errors++;
                $display("FAIL single_done addr=%0d got done_cycle=%0d required %0d", a, done_cyc, hs_cyc + 1);
            end
        end
        rf[7] = 32'h1000_0007;
    endtask

    task automatic test_backpressure();
        int words = 0, done_cyc = -1, stall_left = 0, rise_cyc = -1, w4_cyc = -1;
        bit stalled = 0;
        logic [31:0] hd, ed;
        logic [3:0]  hi, ha, ei;
        logic        el;
        push_full(1'b0);
        kick(1'b0, 4'd0, 1'b0);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (stall_left > 0) begin
                checks++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== hd || sif.out_index !== hi || reg_addr !== ha) begin
                    errors++;
                    $display("FAIL bp_hold got valid=%b data=%h idx=%0d addr=%0d required 1 %h %0d %0d",
                             sif.out_valid, sif.out_data, sif.out_index, reg_addr, hd, hi, ha);
                end
                stall_left--;
                if (stall_left == 0) begin
                    sif.out_ready = 1'b1;
                    rise_cyc      = cyc;
                end
            end else if (sif.out_valid && sif.out_index == 4'd3 && !stalled) begin
                stalled       = 1;
                stall_left    = 5;
                sif.out_ready = 1'b0;
                hd = sif.out_data;
                hi = sif.out_index;
                ha = reg_addr;
            end
            if (sif.out_valid && sif.out_index == 4'd4 && w4_cyc < 0) w4_cyc = cyc;
            if (sif.out_valid && sif.out_ready) begin
                words++;
                checks++;
                if (q_data.size() == 0) begin
                    errors++;
                    $display("FAIL bp_word got extra idx=%0d required none", sif.out_index);
                end else begin
                    ed = q_data.pop_front(); ei = q_idx.pop_front(); el = q_last.pop_front();
                    if (sif.out_data !== ed || sif.out_index !== ei || sif.out_last !== el) begin
                        errors++;
                        $display("FAIL bp_word got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                 sif.out_index, sif.out_data, sif.out_last, ei, ed, el);
                    end
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        sif.out_ready = 1'b1;
        checks++;
        if (rise_cyc < 0 || w4_cyc - rise_cyc != 2) begin
            errors++;
            $display("FAIL bp_resume got word4_delay=%0d required 2", w4_cyc - rise_cyc);
        end
        checks++;
        if (words != 16 || done_cyc != 38) begin
            errors++;
            $display("FAIL bp_count got words=%0d done_cycle=%0d required 16 38", words, done_cyc);
        end
    endtask

    task automatic test_restart_ignored();
        int words = 0, dones = 0, done_cyc = -1;
        bit poked = 0;
        logic [31:0] ed;
        logic [3:0]  ei;
        logic        el;
        push_full(1'b0);
        kick(1'b0, 4'd0, 1'b0);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (sif.out_valid && sif.out_index == 4'd5 && !poked) begin
                poked      = 1;
                start      = 1'b1;
                single     = 1'b1;
                start_addr = 4'd2;
            end
            if (sif.out_valid && sif.out_ready) begin
                words++;
                checks++;
                if (q_data.size() == 0) begin
                    errors++;
                    $display("FAIL restart_word got extra idx=%0d required none", sif.out_index);
                end else begin
                    ed = q_data.pop_front(); ei = q_idx.pop_front(); el = q_last.pop_front();
                    if (sif.out_data !== ed || sif.out_index !== ei || sif.out_last !== el) begin
                        errors++;
                        $display("FAIL restart_word got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                 sif.out_index, sif.out_data, sif.out_last, ei, ed, el);
                    end
                end
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (words != 16 || dones != 1 || done_cyc != 33 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored got words=%0d pulses=%0d done_cycle=%0d busy=%b required 16 1 33 0",
                     words, dones, done_cyc, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int words = 0, dones = 0, bad = 0;
        logic [31:0] ed;
        logic [3:0]  ei;
        logic        el;
        push_full(1'b0);
        kick(1'b0, 4'd0, 1'b0);
        for (int cyc = 1; cyc <= 30 && !found; cyc++) begin
            @(negedge clk);
            if (sif.out_valid && sif.out_index == 4'd9) begin
                found         = 1;
                rst_p         = 1'b1;
                sif.out_ready = 1'b0;
            end else begin
                if (sif.out_valid && sif.out_ready) begin
                    checks++;
                    ed = q_data.pop_front(); ei = q_idx.pop_front(); el = q_last.pop_front();
                    if (sif.out_data !== ed || sif.out_index !== ei || sif.out_last !== el) begin
                        errors++;
                        $display("FAIL rstmid_word got idx=%0d data=%h required idx=%0d data=%h",
                                 sif.out_index, sif.out_data, ei, ed);
                    end
                end
                tick();
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_reach got word9_seen=0 required 1");
        end
        tick();
        rst_p         = 1'b0;
        sif.out_ready = 1'b1;
        checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0 || reg_addr !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort got valid=%b busy=%b addr=%0d done=%b required 0 0 0 0",
                     sif.out_valid, busy, reg_addr, done);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done || sif.out_valid) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_quiet got activity_cycles=%0d required 0", bad);
        end
        q_data.delete();
        q_idx.delete();
        q_last.delete();
        push_full(1'b0);
        kick(1'b0, 4'd0, 1'b0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (sif.out_valid && sif.out_ready) begin
                words++;
                checks++;
                if (q_data.size() == 0) begin
                    errors++;
                    $display("FAIL rstmid_redump got extra idx=%0d required none", sif.out_index);
                end else begin
                    ed = q_data.pop_front(); ei = q_idx.pop_front(); el = q_last.pop_front();
                    if (sif.out_data !== ed || sif.out_index !== ei || sif.out_last !== el) begin
                        errors++;
                        $display("FAIL rstmid_redump got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                 sif.out_index, sif.out_data, sif.out_last, ei, ed, el);
                    end
                end
            end
            if (done) dones++;
            tick();
        end
        checks++;
        if (words != 16 || dones != 1) begin
            errors++;
            $display("FAIL rstmid_count got words=%0d pulses=%0d required 16 1", words, dones);
        end
    endtask

    task automatic test_settle3();
        logic [31:0] ed;
        logic [3:0]  ei;
        logic        el;
        for (int n = 0; n < 2; n++) begin
            int words = 0, first_v = -1, done_cyc = -1;
            if (n == 0) begin
                push_word(4'd5, 1'b1, 1'b1);
                kick(1'b1, 4'd5, 1'b1);
            end else begin
                push_full(1'b1);
                kick(1'b0, 4'd0, 1'b1);
            end
            for (int cyc = 1; cyc <= 70; cyc++) begin
                @(negedge clk);
                if (sif3.out_valid && first_v < 0) first_v = cyc;
                if (sif3.out_valid && sif3.out_ready) begin
                    words++;
                    checks++;
                    if (q_data.size() == 0) begin
                        errors++;
                        $display("FAIL s3_word got extra idx=%0d required none", sif3.out_index);
                    end else begin
                        ed = q_data.pop_front(); ei = q_idx.pop_front(); el = q_last.pop_front();
                        if (sif3.out_data !== ed || sif3.out_index !== ei || sif3.out_last !== el) begin
                            errors++;
                            $display("FAIL s3_word got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                                     sif3.out_index, sif3.out_data, sif3.out_last, ei, ed, el);
                        end
                    end
                end
                if (done3 && done_cyc < 0) done_cyc = cyc;
                tick();
            end
            checks++;
            if (first_v != 4 || words != ((n == 0) ? 1 : 16) || done_cyc != ((n == 0) ? 5 : 65)) begin
                errors++;
                $display("FAIL s3_timing run=%0d got valid_cycle=%0d words=%0d done_cycle=%0d required 4 %0d %0d",
                         n, first_v, words, done_cyc, (n == 0) ? 1 : 16, (n == 0) ? 5 : 65);
            end
        end
    endtask

    initial begin
        rst_p          = 1'b1;
        start          = 1'b0;
        start3         = 1'b0;
        single         = 1'b0;
        start_addr     = 4'd0;
        pc             = 32'h0000_0400;
        sif.out_ready  = 1'b1;
        sif3.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_full_dump();
        test_single();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_settle3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
